// File: rtl/text_cell_scanner.sv
// rtl/text_cell_scanner.sv - pixel stream to text-cell fields for the font lookup
//
// Purpose: walks the active-video pixel stream with incremental cell counters,
// issues the text buffer read address and delays the per-pixel side fields so
// they line up with the synchronous RAM read data.
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   de, sof           active-video strobe, start of frame (with de on first pixel)
//   cursor_en/col/row cursor overlay enable and cell position
//   txt_addr          registered text buffer read address
//   txt_dout          text buffer read data, one cycle after txt_addr
//   cc                character code, txt_dout[6:0]
//   fi                glyph bit index (sub_y*FONT_W + sub_x)
//   off_limits        pixel lies outside the COLS x ROWS text area
//   en                pixel is valid for the glyph lookup
//   cursor_hit        pixel lies inside the visible cursor cell
module text_cell_scanner #(
  parameter int FONT_W       = 10,
  parameter int FONT_H       = 12,
  parameter int COLS         = 64,
  parameter int ROWS         = 40,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                de,
  input  logic                                sof,
  input  logic                                cursor_en,
  input  logic [$clog2(COLS)-1:0]             cursor_col,
  input  logic [$clog2(ROWS)-1:0]             cursor_row,
  output logic [$clog2(COLS*ROWS)-1:0]        txt_addr,
  input  logic [7:0]                          txt_dout,
  output logic [6:0]                          cc,
  output logic [$clog2(FONT_W*FONT_H)-1:0]    fi,
  output logic                                off_limits,
  output logic                                en,
  output logic                                cursor_hit
);

  localparam int SXW = $clog2(FONT_W);
  localparam int SYW = $clog2(FONT_H);
  localparam int CW  = $clog2(COLS + 1);
  localparam int RW  = $clog2(ROWS + 1);
  localparam int LBW = $clog2(COLS * ROWS + 1);
  localparam int AW  = $clog2(COLS * ROWS);
  localparam int FIW = $clog2(FONT_W * FONT_H);
  localparam int FCW = $clog2(BLINK_FRAMES);

  logic [SXW-1:0] sub_x_q, sub_x_d;
  logic [CW-1:0]  col_q, col_d;
  logic [SYW-1:0] sub_y_q, sub_y_d;
  logic [RW-1:0]  row_q, row_d;
  logic [LBW-1:0] line_base_q, line_base_d;
  logic [FIW-1:0] fi_base_q, fi_base_d;
  logic           de_q, de_d;
  logic           synced_q, synced_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic           blink_off_q, blink_off_d;
  // stage 1
  logic [AW-1:0]  txt_addr_q, txt_addr_d;
  logic [FIW-1:0] fi1_q, fi1_d;
  logic           off1_q, off1_d;
  logic           en1_q, en1_d;
  logic           cur1_q, cur1_d;
  // stage 2
  logic [FIW-1:0] fi_q, fi_d;
  logic           off_limits_q, off_limits_d;
  logic           en_q, en_d;
  logic           cursor_hit_q, cursor_hit_d;

  // counters as seen by the current pixel (sof makes this pixel cell (0,0))
  logic           sof_px, valid, off;
  logic [SXW-1:0] e_sub_x;
  logic [CW-1:0]  e_col;
  logic [SYW-1:0] e_sub_y;
  logic [RW-1:0]  e_row;
  logic [LBW-1:0] e_line_base, addr_sum;
  logic [FIW-1:0] e_fi_base;
  logic           unused_dout_msb;

  assign unused_dout_msb = txt_dout[7];

  always_comb begin
    sof_px      = de & sof;
    e_sub_x     = sof_px ? '0 : sub_x_q;
    e_col       = sof_px ? '0 : col_q;
    e_sub_y     = sof_px ? '0 : sub_y_q;
    e_row       = sof_px ? '0 : row_q;
    e_line_base = sof_px ? '0 : line_base_q;
    e_fi_base   = sof_px ? '0 : fi_base_q;

    sub_x_d     = sub_x_q;
    col_d       = col_q;
    sub_y_d     = sub_y_q;
    row_d       = row_q;
    line_base_d = line_base_q;
    fi_base_d   = fi_base_q;
    frame_d     = frame_q;
    blink_off_d = blink_off_q;
    de_d        = de;
    synced_d    = synced_q | sof_px;

    if (de) begin
      sub_y_d     = e_sub_y;
      row_d       = e_row;
      line_base_d = e_line_base;
      fi_base_d   = e_fi_base;
      if (e_sub_x == SXW'(FONT_W - 1)) begin
        sub_x_d = '0;
        col_d   = (e_col == CW'(COLS)) ? e_col : e_col + 1'b1;
      end else begin
        sub_x_d = e_sub_x + 1'b1;
        col_d   = e_col;
      end
    end else if (de_q) begin
      // falling edge of de closes the line
      sub_x_d = '0;
      col_d   = '0;
      if (sub_y_q == SYW'(FONT_H - 1)) begin
        sub_y_d   = '0;
        fi_base_d = '0;
        // row and line_base saturate together so line_base stays row*COLS
        if (row_q != RW'(ROWS)) begin
          row_d       = row_q + 1'b1;
          line_base_d = line_base_q + LBW'(COLS);
        end
      end else begin
        sub_y_d   = sub_y_q + 1'b1;
        fi_base_d = fi_base_q + FIW'(FONT_W);
      end
    end

    if (sof_px) begin
      if (frame_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_d     = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // stage 1: everything is zeroed unless this is a synced active pixel
    valid      = de & (synced_q | sof_px);
    off        = (e_col >= CW'(COLS)) | (e_row >= RW'(ROWS));
    addr_sum   = e_line_base + LBW'(e_col);
    txt_addr_d = (valid & ~off) ? AW'(addr_sum) : '0;
    fi1_d      = valid ? (e_fi_base + FIW'(e_sub_x)) : '0;
    off1_d     = valid & off;
    en1_d      = valid;
    cur1_d     = valid & cursor_en & ~blink_off_q &
                 (e_col == CW'(cursor_col)) & (e_row == RW'(cursor_row));

    // stage 2 lines up with txt_dout
    fi_d         = fi1_q;
    off_limits_d = off1_q;
    en_d         = en1_q;
    cursor_hit_d = cur1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_x_q      <= '0;
      col_q        <= '0;
      sub_y_q      <= '0;
      row_q        <= '0;
      line_base_q  <= '0;
      fi_base_q    <= '0;
      de_q         <= 1'b0;
      synced_q     <= 1'b0;
      frame_q      <= '0;
      blink_off_q  <= 1'b0;
      txt_addr_q   <= '0;
      fi1_q        <= '0;
      off1_q       <= 1'b0;
      en1_q        <= 1'b0;
      cur1_q       <= 1'b0;
      fi_q         <= '0;
      off_limits_q <= 1'b0;
      en_q         <= 1'b0;
      cursor_hit_q <= 1'b0;
    end else begin
      sub_x_q      <= sub_x_d;
      col_q        <= col_d;
      sub_y_q      <= sub_y_d;
      row_q        <= row_d;
      line_base_q  <= line_base_d;
      fi_base_q    <= fi_base_d;
      de_q         <= de_d;
      synced_q     <= synced_d;
      frame_q      <= frame_d;
      blink_off_q  <= blink_off_d;
      txt_addr_q   <= txt_addr_d;
      fi1_q        <= fi1_d;
      off1_q       <= off1_d;
      en1_q        <= en1_d;
      cur1_q       <= cur1_d;
      fi_q         <= fi_d;
      off_limits_q <= off_limits_d;
      en_q         <= en_d;
      cursor_hit_q <= cursor_hit_d;
    end
  end

  assign txt_addr   = txt_addr_q;
  assign cc         = txt_dout[6:0];
  assign fi         = fi_q;
  assign off_limits = off_limits_q;
  assign en         = en_q;
  assign cursor_hit = cursor_hit_q;

endmodule

// File: tb/tb_text_cell_scanner.sv
// tb/tb_text_cell_scanner.sv - self-checking bench for text_cell_scanner
module tb_text_cell_scanner;

  localparam int FONT_W = 10;
  localparam int FONT_H = 12;
  localparam int COLS   = 64;
  localparam int ROWS   = 40;
  localparam int BLINK  = 30;
  localparam int AW     = $clog2(COLS * ROWS);
  localparam int FIW    = $clog2(FONT_W * FONT_H);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    de = 1'b0;
  logic                    sof = 1'b0;
  logic                    cursor_en = 1'b0;
  logic [$clog2(COLS)-1:0] cursor_col = '0;
  logic [$clog2(ROWS)-1:0] cursor_row = '0;
  logic [AW-1:0]           txt_addr;
  logic [7:0]              txt_dout = '0;
  logic [6:0]              cc;
  logic [FIW-1:0]          fi;
  logic                    off_limits, en, cursor_hit;

  logic [7:0] ram [COLS*ROWS];

  text_cell_scanner #(
    .FONT_W(FONT_W), .FONT_H(FONT_H), .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .de(de), .sof(sof), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .txt_addr(txt_addr),
    .txt_dout(txt_dout), .cc(cc), .fi(fi), .off_limits(off_limits), .en(en),
    .cursor_hit(cursor_hit)
  );

  always #5 clk = ~clk;

  // synchronous text buffer
  always @(posedge clk) txt_dout <= ram[txt_addr];

  typedef struct {
    int addr;
    int fi;
    bit off;
    bit en;
    bit cur;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   hit_cnt = 0;
  int   en_cnt = 0;
  exp_t pend, p1, p2, tmp;
  exp_t zero_e = '{default: 0};

  // behavioural model state: pixel position inside the line and frame
  int mx = 0, my = 0, msof_cnt = 0;
  bit msync = 0, prev_de = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t fields(int x, int y, bit cen, int ccol, int crow, bit vis);
    exp_t e;
    int c, r;
    c      = x / FONT_W;
    r      = y / FONT_H;
    e.en   = 1;
    e.off  = (c >= COLS) || (r >= ROWS);
    e.addr = e.off ? 0 : r * COLS + c;
    e.fi   = (y % FONT_H) * FONT_W + (x % FONT_W);
    e.cur  = cen && vis && (c == ccol) && (r == crow);
    return e;
  endfunction

  function automatic exp_t model(bit d, bit s);
    exp_t e;
    bit vis;
    e = '{default: 0};
    if (d) begin
      if (s) begin
        mx = 0;
        my = 0;
      end
      if (msync || s) begin
        vis = ((msof_cnt / BLINK) % 2) == 0;
        e = fields(mx, my, cursor_en, int'(cursor_col), int'(cursor_row), vis);
      end
      if (s) begin
        msync = 1;
        msof_cnt++;
      end
      mx++;
    end else if (prev_de) begin
      mx = 0;
      my++;
    end
    prev_de = d;
    return e;
  endfunction

  task automatic step(input bit d, input bit s);
    @(negedge clk);
    p2 = p1;
    p1 = pend;
    chk("txt_addr", int'(txt_addr), p1.addr);
    chk("fi", int'(fi), p2.fi);
    chk("off_limits", int'(off_limits), int'(p2.off));
    chk("en", int'(en), int'(p2.en));
    chk("cursor_hit", int'(cursor_hit), int'(p2.cur));
    chk("cc", int'(cc), int'(ram[p2.addr][6:0]));
    if (cursor_hit) hit_cnt++;
    if (en) en_cnt++;
    de   = d;
    sof  = s;
    pend = model(d, s);
  endtask

  task automatic run_line(input int n, input bit s, input int gap);
    for (int i = 0; i < n; i++) step(1'b1, s && (i == 0));
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    de  = 1'b0;
    sof = 1'b0;
    pend = zero_e;
    p1 = zero_e;
    p2 = zero_e;
    mx = 0; my = 0; msof_cnt = 0; msync = 0; prev_de = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < COLS * ROWS; i++) ram[i] = 8'($urandom);
    ram[0] = 8'hC1;
    pend = zero_e;
    p1 = zero_e;
    p2 = zero_e;

    // hand-computed points pinning the model
    tmp = fields(125, 0, 0, 0, 0, 1);
    chk("model_addr_125_0", tmp.addr, 12);
    chk("model_fi_125_0", tmp.fi, 5);
    tmp = fields(7, 11, 0, 0, 0, 1);
    chk("model_fi_7_11", tmp.fi, 117);
    tmp = fields(639, 12, 0, 0, 0, 1);
    chk("model_addr_639_12", tmp.addr, 127);
    chk("model_fi_639_12", tmp.fi, 9);
    tmp = fields(650, 0, 0, 0, 0, 1);
    chk("model_off_650_0", int'(tmp.off), 1);
    chk("model_addr_650_0", tmp.addr, 0);
    tmp = fields(5, 485, 0, 0, 0, 1);
    chk("model_off_row", int'(tmp.off), 1);
    tmp = fields(35, 28, 1, 3, 2, 1);
    chk("model_cur_in", int'(tmp.cur), 1);
    tmp = fields(40, 28, 1, 3, 2, 1);
    chk("model_cur_out", int'(tmp.cur), 0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txt_addr", int'(txt_addr), 0);
    chk("rst_fi", int'(fi), 0);
    chk("rst_off_limits", int'(off_limits), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_cursor_hit", int'(cursor_hit), 0);
    rst = 1'b0;

    // first frame: line 0 with character read alignment, then 12 more lines
    step(1, 1);
    step(1, 0);
    step(1, 0);
    chk("first_en", int'(en), 1);
    chk("first_fi", int'(fi), 0);
    chk("first_cc", int'(cc), 'h41);
    for (int i = 3; i < 640; i++) step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int l = 0; l < 12; l++) run_line(640, 0, 2);

    // overlong line past COLS, then a normal line
    run_line(700, 1, 2);
    run_line(640, 0, 2);

    // many short lines to run past ROWS
    run_line(12, 1, 1);
    for (int l = 0; l < 489; l++) run_line(12, 0, 1);

    // cursor and blink, counted from a fresh reset
    do_reset();
    cursor_en = 1'b1;
    cursor_col = 3;
    cursor_row = 2;
    hit_cnt = 0;
    run_line(45, 1, 2);
    for (int l = 0; l < 39; l++) run_line(45, 0, 2);
    chk("cursor_hits_visible", hit_cnt, 120);
    for (int f = 0; f < 29; f++) run_line(4, 1, 2);
    hit_cnt = 0;
    run_line(45, 1, 2);
    for (int l = 0; l < 39; l++) run_line(45, 0, 2);
    chk("cursor_hits_blinked", hit_cnt, 0);
    for (int f = 0; f < 29; f++) run_line(4, 1, 2);
    hit_cnt = 0;
    run_line(45, 1, 2);
    for (int l = 0; l < 39; l++) run_line(45, 0, 2);
    chk("cursor_hits_back", hit_cnt, 120);
    cursor_en = 1'b0;

    // reset in the middle of line 5, then unsynced pixels until the next sof
    run_line(640, 1, 2);
    for (int l = 0; l < 4; l++) run_line(640, 0, 2);
    for (int i = 0; i < 200; i++) step(1, 0);
    do_reset();
    en_cnt = 0;
    for (int i = 0; i < 300; i++) step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int l = 0; l < 2; l++) run_line(640, 0, 2);
    chk("unsynced_en_count", en_cnt, 0);
    step(1, 1);
    step(1, 0);
    chk("resync_txt_addr", int'(txt_addr), 0);
    step(1, 0);
    chk("resync_en", int'(en), 1);
    chk("resync_fi", int'(fi), 0);
    for (int i = 3; i < 640; i++) step(1, 0);
    step(0, 0);
    step(0, 0);

    // randomized frames: line lengths, gaps, stray sof, cursor position
    for (int f = 0; f < 8; f++) begin
      int nl;
      cursor_en  = 1'($urandom);
      cursor_col = 6'($urandom_range(0, 63));
      cursor_row = 6'($urandom_range(0, 2));
      nl = $urandom_range(1, 15);
      for (int l = 0; l < nl; l++) begin
        int len;
        len = $urandom_range(1, 700);
        for (int i = 0; i < len; i++)
          step(1'b1, ((l == 0) && (i == 0)) || ($urandom_range(0, 999) == 0));
        run_line(0, 0, $urandom_range(1, 4));
      end
    end
    step(0, 0);
    step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
